// File: rtl/fifo_8.sv
// fifo_8: 4-entry circular byte buffer with registered read data, occupancy flags and sticky overflow/underflow error.
module fifo_8 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  do_rd, do_wr;
  assign full         = count == (ADDR_WIDTH+1)'(DEPTH);
  assign empty        = count == '0;
  assign almost_full  = count >= (ADDR_WIDTH+1)'(AF_THRESH);
  assign almost_empty = count <= (ADDR_WIDTH+1)'(AE_THRESH);
  // a pop frees a slot on the same edge, so a push into a full buffer still lands
  assign do_rd = pop && !empty;
  assign do_wr = push && (!full || do_rd);
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= data_in;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      wr_ptr    <= do_wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr    <= do_rd ? rd_ptr + 1'b1 : rd_ptr;
      count     <= (do_wr && !do_rd) ? count + ONE : (do_rd && !do_wr) ? count - ONE : count;
      data_out  <= do_rd ? mem[rd_ptr] : data_out;
      valid_out <= do_rd;
      error     <= error || (push && !do_wr) || (pop && !do_rd);
    end
  end
endmodule

// File: doc/fifo_8.md
Name: fifo_8

Overview:
- Per-port buffer sitting directly downstream of the 1-to-2 byte demultiplexer; one instance per demux output.
- Absorbs the demux's byte stream (out0 with push_0, or out1 with push_1) and stores it in a small circular buffer.
- Releases bytes on pop to the next switch stage.
- Exports full/empty and almost-full/almost-empty flags that the upstream flow-control logic uses to throttle valid_in and select.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 2, pointer width; DEPTH = 2**ADDR_WIDTH = 4 entries.
- AF_THRESH, 3, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  DATA_WIDTH  write data; connects to demux out0 or out1.
- push  input  1  write request; connects to demux push_0 or push_1.
- pop  input  1  read request from downstream stage.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  data_out holds a word popped on the previous edge.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- error  output  1  sticky overflow/underflow indicator.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- State: mem[DEPTH], wr_ptr, rd_ptr (ADDR_WIDTH bits each, wrap modulo DEPTH), count register, data_out/valid_out/error registers.
- Reset (reset=1 at rising edge), applies regardless of push/pop, including mid-stream:
  - wr_ptr=0, rd_ptr=0, count=0.
  - data_out=0, valid_out=0, error=0.
  - Flags after reset: empty=1, full=0, almost_empty=1, almost_full=0.
  - mem contents are not cleared and are don't-care.
- Status flags are combinational decodes of the registered count, so they reflect state after the last edge.
- All push/pop legality is evaluated against the pre-edge count.
- Write: push=1 and count<DEPTH (or push with a simultaneous legal pop) -> mem[wr_ptr]<=data_in, wr_ptr<=wr_ptr+1.
- Read, 1-cycle latency: pop=1 and count>0 -> data_out<=mem[rd_ptr], valid_out<=1, rd_ptr<=rd_ptr+1.
- No legal pop on an edge -> valid_out<=0; data_out holds its last value.
- count update per edge: +1 on write only, -1 on read only, unchanged on both or neither.
- Push when full, no pop: word dropped, pointers and count unchanged, error<=1.
- Push and pop when full: both succeed, count stays DEPTH, no error.
- Pop when empty: ignored, valid_out<=0, error<=1; this holds even with a simultaneous push. The push still writes, so count becomes 1. There is no fall-through.
- Push and pop when 0<count<DEPTH: both succeed; pointers advance independently.
- error is sticky: once set it stays 1 until reset.
- Pointer wrap: DEPTH-1 -> 0 with no bubble; FIFO ordering is preserved across the wrap.
- No combinational path from inputs to any output other than through count.

Test Plan:
- Reset: hold reset=1 for 2 cycles with push=1, data_in=8'hFF -> count=0, empty=1, almost_empty=1, valid_out=0, error=0, data_out=0.
- Fill to full: push 8'hFF, 8'hDD, 8'hEE, 8'hCC on 4 consecutive edges.
  - count steps 1,2,3,4.
  - almost_empty drops after count=2.
  - almost_full rises at count=3.
  - full=1 at count=4.
  - A 5th push of 8'hBB leaves count=4 and sets error=1.
- Drain in order: from full, pop for 4 cycles -> on the edge after each pop, data_out = FF, DD, EE, CC with valid_out=1. Then empty=1. A 5th pop gives valid_out=0 and error stays 1.
- Simultaneous push/pop at full:
  - Setup: after reset, fill with 88, 99, AA, BB.
  - Stimulus: push 8'h77 with pop=1.
  - Response: data_out=88, count=4, error=0. Subsequent drain yields 99, AA, BB, 77, which exercises pointer wrap.
- Underflow with push: from empty, push=1 with data_in=8'h55 and pop=1 -> count=1, valid_out=0, error=1. Next pop yields data_out=55.
- Demux integration: demux fed FF/sel0, DD/sel1 x3, EE/sel0 -> fifo_0 holds FF, EE (count=2) and fifo_1 holds DD, DD, DD (count=3, almost_full=1).
